serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of bits per parallel word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first serial bit lands in pout[WIDTH-1]; 0 means it lands in pout[0].
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sin  input  1  serial data bit, sampled only when sin_valid=1.
REQ-006 sin_valid  input  1  qualifies sin for the current cycle.
REQ-007 clr  input  1  synchronous abort: discards the partial word and clears overrun.
REQ-008 pout  output  WIDTH  last completed parallel word.
REQ-009 out_valid  output  1  pout holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts pout when out_valid=1 and out_ready=1.
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 busy  output  1  high while a partial word is being collected.

Function
REQ-013 FSM states: IDLE (bit count 0) and SHIFT (1..WIDTH-1 bits collected).
REQ-014 IDLE: sin_valid=1 captures one bit, sets the count to 1 and moves to SHIFT; sin_valid=0 stays in IDLE.
REQ-015 SHIFT: each sin_valid=1 cycle shifts one bit in and increments the count; sin_valid=0 holds the state, count and shift contents.
REQ-016 When the WIDTH-th bit is captured, the FSM returns to IDLE with count 0, and the completed word is offered to the output buffer in that same edge.
REQ-017 Latency: pout and out_valid update on the same rising edge that captures the final bit.
REQ-018 Output buffer is one word deep:
- Loads when out_valid=0, or when out_valid=1 and out_ready=1 in the completing cycle (back-to-back transfer; out_valid stays 1).
REQ-019 Overrun:
- Completing while out_valid=1 and out_ready=0 drops the new word, leaves pout unchanged and sets overrun.
- overrun stays set until clr or rst.
REQ-020 Handshake clearing: out_valid=1 and out_ready=1 with no completing word clears out_valid on the next edge; pout keeps its last value.
REQ-021 pout and out_valid do not change while out_valid=1 and out_ready=0, except as stated in REQ-019.
REQ-022 clr=1:
- Forces IDLE with count 0 and clears overrun.
- Discards any bit presented in the same cycle.
- Does not affect pout or out_valid; an out_ready handshake in the same cycle still completes.
REQ-023 busy is 1 exactly when the state is SHIFT.
REQ-024 The count register is ceil(log2(WIDTH)) bits wide and never exceeds WIDTH-1.

Reset
REQ-025 Asserting rst immediately, and asynchronously, forces: state IDLE, count 0, shift register 0, pout 0, out_valid 0, overrun 0, busy 0.
REQ-026 A partial word in progress when rst asserts is discarded.
REQ-027 The first sin_valid bit is accepted on the first rising edge after rst deasserts.

Structure
REQ-028 A shared package serial_pkg holds the FSM state enum (IDLE, SHIFT) and the default-WIDTH constant.
REQ-029 The shift path is a sub-module named shift_reg:
- Parameterized by WIDTH and MSB_FIRST.
- Ports: clk, rst, shift_en, clr, sin, q.
- Built from per-bit flip-flops with asynchronous active-high reset.
REQ-030 The FSM, count and output buffer stay in serial_deserializer; there are no combinational paths from sin to pout.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, out_ready=1; send bits 1,0,1,0,0,1,0,1 on consecutive cycles -> pout=8'hA5 with out_valid=1 for exactly one cycle, on the 8th capture edge.
REQ-032 Same setup with MSB_FIRST=0 and the same bit order -> pout=8'hA5 reversed = 8'hA5 is symmetric, so use bits 1,1,0,0,0,0,0,0 instead -> pout=8'h03.
REQ-033 Hold out_ready=0; send 8'h3C, then 8'hC3 -> pout stays 8'h3C, out_valid=1, overrun=1; pulse clr -> overrun=0 and pout=8'h3C is still valid.
REQ-034 Insert sin_valid=0 gaps of 0..3 cycles between bits of 8'h5A -> pout=8'h5A, and busy=1 throughout the gaps.
REQ-035 Assert rst after 5 bits (busy=1), then send 8'hFF -> all outputs 0 during reset, and the next word is exactly 8'hFF with no stale bits.
REQ-036 With out_valid=1 holding 8'h11, the 8th bit of 8'h22 and out_ready=1 arrive in the same cycle -> pout=8'h22, out_valid stays 1, overrun=0.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_pkg : shared FSM state type and default word width          |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package serial_pkg;
  localparam int unsigned c_DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/serial_deserializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_deserializer_if : serial input / parallel output bundle     |
// | Revision               : 1.0                                       |
// +--------------------------------------------------------------------+
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_valid;
  logic             clr;
  logic [WIDTH-1:0] pout;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             busy;

  modport master (
    output sin, sin_valid, clr, out_ready,
    input  pout, out_valid, overrun, busy
  );

  modport slave (
    input  sin, sin_valid, clr, out_ready,
    output pout, out_valid, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_reg : per-bit flip-flop shift register, selectable direction |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             shift_en,
  input  wire logic             clr,
  input  wire logic             sin,
  output logic      [WIDTH-1:0] q
);
  logic [WIDTH-1:0] w_d;

  // MSB-first shifts toward the top so the oldest bit ends in q[WIDTH-1].
  assign w_d = MSB_FIRST ? {q[WIDTH-2:0], sin} : {sin, q[WIDTH-1:1]};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic r_bit;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_bit <= 1'b0;
        end else if (clr) begin
          r_bit <= 1'b0;
        end else if (shift_en) begin
          r_bit <= w_d[i];
        end
      end
      assign q[i] = r_bit;
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_deserializer : serial-to-parallel with 1-deep output buffer |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = c_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  serial_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_pout, w_pout_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_word;
  logic             w_cap, w_done, w_load, w_drop;

  assign w_cap = bus.sin_valid && !bus.clr;

  shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_cap),
    .clr      (bus.clr),
    .sin      (bus.sin),
    .q        (w_q)
  );

  // The completed word includes the bit being captured on this edge.
  assign w_word = MSB_FIRST ? {w_q[WIDTH-2:0], bus.sin} : {bus.sin, w_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_pout      <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_pout      <= w_pout_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_pout_nxt      = r_pout;
    w_out_valid_nxt = r_out_valid;
    w_overrun_nxt   = r_overrun;
    w_done          = w_cap && (r_state == SHIFT) && (r_count == c_LAST);
    w_load          = w_done && (!r_out_valid || bus.out_ready);
    w_drop          = w_done && r_out_valid && !bus.out_ready;

    if (bus.clr) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end else if (w_cap) begin
      if (w_done) begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end else begin
        w_state_nxt = SHIFT;
        w_count_nxt = r_count + CNT_W'(1);
      end
    end

    if (w_load) begin
      w_pout_nxt      = w_word;
      w_out_valid_nxt = 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (bus.clr) begin
      w_overrun_nxt = 1'b0;
    end else if (w_drop) begin
      w_overrun_nxt = 1'b1;
    end
  end

  assign bus.pout      = r_pout;
  assign bus.out_valid = r_out_valid;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = (r_state == SHIFT);
endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_deserializer : directed bench, MSB-first and LSB-first   |
// | Revision               : 1.0                                       |
// +--------------------------------------------------------------------+
module tb_serial_deserializer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_deserializer_if #(.WIDTH(8)) m_if ();
  serial_deserializer_if #(.WIDTH(8)) l_if ();

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (l_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word_m(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      m_if.sin       = w[i];
      m_if.sin_valid = 1'b1;
      tick();
    end
    m_if.sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.overrun, m_if.busy} !== 11'h0) begin
      n_errors++;
      $display("FAIL reset_state: got %h required 000", {m_if.pout, m_if.out_valid, m_if.overrun, m_if.busy});
    end
    rst = 1'b0;
  endtask

  task automatic test_msb_basic();
    logic [7:0] w;
    w = 8'hA5;
    m_if.out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      m_if.sin       = w[i];
      m_if.sin_valid = 1'b1;
      tick();
      if (i == 7) begin
        n_checks++;
        if (m_if.busy !== 1'b1) begin
          n_errors++;
          $display("FAIL basic_busy_first: got %b required 1", m_if.busy);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (m_if.out_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL basic_early_valid: got %b required 0", m_if.out_valid);
        end
      end
    end
    m_if.sin_valid = 1'b0;
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.busy} !== {8'hA5, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL basic_word: got pout=%h v=%b busy=%b required A5 1 0", m_if.pout, m_if.out_valid, m_if.busy);
    end
    tick();
    n_checks++;
    if ({m_if.pout, m_if.out_valid} !== {8'hA5, 1'b0}) begin
      n_errors++;
      $display("FAIL basic_one_cycle: got pout=%h v=%b required A5 0", m_if.pout, m_if.out_valid);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'b1100_0000;
    l_if.out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      l_if.sin       = seq[i];
      l_if.sin_valid = 1'b1;
      tick();
    end
    l_if.sin_valid = 1'b0;
    n_checks++;
    if ({l_if.pout, l_if.out_valid} !== {8'h03, 1'b1}) begin
      n_errors++;
      $display("FAIL lsb_word: got pout=%h v=%b required 03 1", l_if.pout, l_if.out_valid);
    end
  endtask

  task automatic test_overrun();
    m_if.out_ready = 1'b0;
    send_word_m(8'h3C);
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.overrun} !== {8'h3C, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL ovr_first: got pout=%h v=%b ovr=%b required 3C 1 0", m_if.pout, m_if.out_valid, m_if.overrun);
    end
    send_word_m(8'hC3);
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.overrun} !== {8'h3C, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL ovr_drop: got pout=%h v=%b ovr=%b required 3C 1 1", m_if.pout, m_if.out_valid, m_if.overrun);
    end
    repeat (3) tick();
    n_checks++;
    if (m_if.overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL ovr_sticky: got %b required 1", m_if.overrun);
    end
    m_if.clr = 1'b1;
    tick();
    m_if.clr = 1'b0;
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.overrun} !== {8'h3C, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL ovr_clr: got pout=%h v=%b ovr=%b required 3C 1 0", m_if.pout, m_if.out_valid, m_if.overrun);
    end
    m_if.out_ready = 1'b1;
    tick();
    n_checks++;
    if ({m_if.pout, m_if.out_valid} !== {8'h3C, 1'b0}) begin
      n_errors++;
      $display("FAIL ovr_drain: got pout=%h v=%b required 3C 0", m_if.pout, m_if.out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h5A;
    m_if.out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      m_if.sin       = w[i];
      m_if.sin_valid = 1'b1;
      tick();
      m_if.sin       = ~w[i];
      m_if.sin_valid = 1'b0;
      if (i > 0) begin
        for (int g = 0; g < (i % 4); g++) begin
          tick();
          n_checks++;
          if ({m_if.busy, m_if.out_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL gap_busy bit%0d: got busy=%b v=%b required 1 0", i, m_if.busy, m_if.out_valid);
          end
        end
      end
    end
    n_checks++;
    if ({m_if.pout, m_if.out_valid} !== {8'h5A, 1'b1}) begin
      n_errors++;
      $display("FAIL gap_word: got pout=%h v=%b required 5A 1", m_if.pout, m_if.out_valid);
    end
    tick();
  endtask

  task automatic test_clr_abort();
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_if.sin       = 1'b1;
      m_if.sin_valid = 1'b1;
      tick();
    end
    m_if.clr = 1'b1;
    tick();
    m_if.clr       = 1'b0;
    m_if.sin_valid = 1'b0;
    n_checks++;
    if (m_if.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_idle: got busy=%b required 0", m_if.busy);
    end
    send_word_m(8'h96);
    n_checks++;
    if ({m_if.pout, m_if.out_valid} !== {8'h96, 1'b1}) begin
      n_errors++;
      $display("FAIL clr_next_word: got pout=%h v=%b required 96 1", m_if.pout, m_if.out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    m_if.out_ready = 1'b0;
    send_word_m(8'h11);
    w = 8'h22;
    for (int i = 7; i >= 0; i--) begin
      m_if.sin       = w[i];
      m_if.sin_valid = 1'b1;
      m_if.out_ready = (i == 0);
      tick();
    end
    m_if.sin_valid = 1'b0;
    m_if.out_ready = 1'b0;
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.overrun} !== {8'h22, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_word: got pout=%h v=%b ovr=%b required 22 1 0", m_if.pout, m_if.out_valid, m_if.overrun);
    end
  endtask

  task automatic test_async_reset();
    m_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_if.sin       = 1'b1;
      m_if.sin_valid = 1'b1;
      tick();
    end
    m_if.sin_valid = 1'b0;
    n_checks++;
    if (m_if.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre_busy: got %b required 1", m_if.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m_if.pout, m_if.out_valid, m_if.overrun, m_if.busy} !== 11'h0) begin
      n_errors++;
      $display("FAIL rst_async: got %h required 000", {m_if.pout, m_if.out_valid, m_if.overrun, m_if.busy});
    end
    tick();
    rst = 1'b0;
    m_if.out_ready = 1'b1;
    send_word_m(8'hFF);
    n_checks++;
    if ({m_if.pout, m_if.out_valid} !== {8'hFF, 1'b1}) begin
      n_errors++;
      $display("FAIL rst_next_word: got pout=%h v=%b required FF 1", m_if.pout, m_if.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    m_if.sin = 1'b0; m_if.sin_valid = 1'b0; m_if.clr = 1'b0; m_if.out_ready = 1'b0;
    l_if.sin = 1'b0; l_if.sin_valid = 1'b0; l_if.clr = 1'b0; l_if.out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_msb_basic();
    test_lsb_first();
    test_overrun();
    test_gaps();
    test_clr_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
